// File: rtl/logic_unit_pkg.sv
// Purpose : Shared types and constants for the bit-serial logic unit and the
//           parallel logic gate family.
// Contents: op_t    - 2-bit bitwise operation code (fully decoded)
//           state_t - serial sequencer state
//           LU_WIDTH - default operand/result width
package logic_unit_pkg;

    localparam int LU_WIDTH = 18;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_bit_slice.sv
// Purpose : One-bit combinational logic cell. Evaluates the selected bitwise
//           operation on a single pair of operand bits.
// Ports   : op    in  op_t  operation select
//           a_bit in  1     operand A bit
//           b_bit in  1     operand B bit
//           y     out 1     result bit
module logic_bit_slice
    import logic_unit_pkg::*;
(
    input  op_t  op,
    input  logic a_bit,
    input  logic b_bit,
    output logic y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = a_bit & b_bit;
            OP_OR:   y = a_bit | b_bit;
            OP_XOR:  y = a_bit ^ b_bit;
            OP_NAND: y = ~(a_bit & b_bit);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit_18.sv
// Purpose : Bit-serial bitwise logic unit. Captures two operands and an op
//           code on start, evaluates one bit per clock LSB first, streams each
//           result bit on ser_out and reassembles the parallel result, which is
//           published together with a one-cycle done pulse.
// Handshake: start is sampled only while busy=0 (state IDLE); a start seen in
//           that cycle is accepted at the next rising edge and the first result
//           bit appears in the following cycle. start while busy=1 is ignored.
//           ser_out is meaningful only while ser_valid=1 and is 0 otherwise.
// Ports   : clk       in  1      clock, rising edge
//           rst       in  1      asynchronous active-high reset
//           start     in  1      operation request
//           a, b      in  WIDTH  operands, captured on accepted start
//           op        in  2      operation code (logic_unit_pkg::op_t)
//           busy      out 1      bits are being evaluated
//           ser_valid out 1      ser_out carries a result bit
//           ser_out   out 1      current result bit, LSB first
//           done      out 1      one-cycle pulse when result updates
//           result    out WIDTH  last completed result
//           state     out state_t sequencer state, for observation
module serial_logic_unit_18
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output state_t           state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Operand shift registers hold only the bits not yet evaluated: bit 0 of
    // each operand is consumed directly from the inputs at capture time.
    logic [WIDTH-2:0] sh_a;
    logic [WIDTH-2:0] sh_b;
    op_t              op_q;
    logic [CNT_W-1:0] cnt;
    // Collects the first WIDTH-1 result bits; the final bit is taken straight
    // from ser_out when the result is published.
    logic [WIDTH-2:0] acc;

    op_t  slice_op;
    logic slice_a;
    logic slice_b;
    logic slice_y;

    // The single slice computes the bit that ser_out will carry next cycle:
    // bit 0 from the raw inputs while idle, otherwise the next captured bit.
    always_comb begin
        slice_op = op_t'(op);
        slice_a  = a[0];
        slice_b  = b[0];
        if (state == RUN) begin
            slice_op = op_q;
            slice_a  = sh_a[0];
            slice_b  = sh_b[0];
        end
    end

    logic_bit_slice u_slice (
        .op    (slice_op),
        .a_bit (slice_a),
        .b_bit (slice_b),
        .y     (slice_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            op_q      <= OP_AND;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        ser_valid <= 1'b1;
                        ser_out   <= slice_y;
                        sh_a      <= a[WIDTH-1:1];
                        sh_b      <= b[WIDTH-1:1];
                        op_q      <= op_t'(op);
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    acc     <= {ser_out, acc[WIDTH-2:1]};
                    sh_a    <= sh_a >> 1;
                    sh_b    <= sh_b >> 1;
                    ser_out <= slice_y;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_out   <= 1'b0;
                        done      <= 1'b1;
                        result    <= {ser_out, acc};
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_logic_unit_18.sv
module tb_serial_logic_unit_18;
    import logic_unit_pkg::*;

    localparam int W = 18;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         busy;
    logic         ser_valid;
    logic         ser_out;
    logic         done;
    logic [W-1:0] result;
    state_t       state;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[9];

    serial_logic_unit_18 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .busy      (busy),
        .ser_valid (ser_valid),
        .ser_out   (ser_out),
        .done      (done),
        .result    (result),
        .state     (state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", name, act, req);
        end
    endtask

    task automatic check_idle(input string tag, input logic [W-1:0] res_req);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " ser_valid"}, ser_valid, 1'b0);
        chk1({tag, " ser_out"}, ser_out, 1'b0);
        chk1({tag, " done"}, done, 1'b0);
        chk1({tag, " state"}, state == RUN, 1'b0);
        chkw({tag, " result"}, result, res_req);
    endtask

    // Called #1 after a rising edge; leaves the bench #1 into cycle 1.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Checks cycles 1..W (streamed bits, held result) and the done cycle.
    // With noise set, start is held high with fresh random operands during
    // cycles 2..W; they must not disturb the running op.
    task automatic stream(input string tag, input logic [W-1:0] res_req,
                          input logic [W-1:0] prev, input bit noise);
        for (int k = 0; k < W; k++) begin
            chk1($sformatf("%s busy c%0d", tag, k + 1), busy, 1'b1);
            chk1($sformatf("%s ser_valid c%0d", tag, k + 1), ser_valid, 1'b1);
            chk1($sformatf("%s ser_out c%0d", tag, k + 1), ser_out, res_req[k]);
            chk1($sformatf("%s done c%0d", tag, k + 1), done, 1'b0);
            chkw($sformatf("%s result hold c%0d", tag, k + 1), result, prev);
            if (noise && k >= 1) begin
                start = 1'b1;
                a     = W'($urandom_range(0, 18'h3FFFF));
                b     = W'($urandom_range(0, 18'h3FFFF));
                op    = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
        end
        chk1({tag, " done pulse"}, done, 1'b1);
        chk1({tag, " busy end"}, busy, 1'b0);
        chk1({tag, " ser_valid end"}, ser_valid, 1'b0);
        chk1({tag, " ser_out end"}, ser_out, 1'b0);
        chkw({tag, " result"}, result, res_req);
    endtask

    initial begin
        logic [W-1:0] prev;

        vecs[0] = '{OP_AND,  18'h3FFFF, 18'h2AAAA, 18'h2AAAA};
        vecs[1] = '{OP_OR,   18'h00F0F, 18'h30000, 18'h30F0F};
        vecs[2] = '{OP_XOR,  18'h01234, 18'h01234, 18'h00000};
        vecs[3] = '{OP_NAND, 18'h00000, 18'h00000, 18'h3FFFF};
        vecs[4] = '{OP_AND,  18'h0F0F0, 18'h3C3C3, 18'h0C0C0};
        vecs[5] = '{OP_XOR,  18'h3FFFF, 18'h15555, 18'h2AAAA};
        vecs[6] = '{OP_NAND, 18'h3FFFF, 18'h3FFFF, 18'h00000};
        vecs[7] = '{OP_OR,   18'h20001, 18'h00000, 18'h20001};
        vecs[8] = '{OP_NAND, 18'h2AAAA, 18'h15555, 18'h3FFFF};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", '0);
        rst = 1'b0;

        // idle with start low
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("idle%0d", i), '0);
        end

        // table vectors, issued back to back from the done cycle
        prev = '0;
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            stream($sformatf("vec%0d", i), vecs[i].res, prev, 1'b0);
            prev = vecs[i].res;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("post_vec%0d", i), prev);
        end

        // start held high with changing operands while busy
        start_op(OP_AND, 18'h3FFFF, 18'h2AAAA);
        stream("busy_start", 18'h2AAAA, prev, 1'b1);
        start_op(OP_OR, 18'h00F0F, 18'h30000);
        stream("after_busy", 18'h30F0F, 18'h2AAAA, 1'b0);
        @(posedge clk);
        #1;
        check_idle("after_busy idle", 18'h30F0F);

        // reset in cycle 8 of an op
        start_op(OP_XOR, 18'h3FFFF, 18'h15555);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk1("pre_rst busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_idle("rst_mid", '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("post_rst%0d", i), '0);
        end
        start_op(OP_NAND, 18'h0F0F0, 18'h3C3C3);
        stream("fresh", 18'h33F3F, '0, 1'b0);
        @(posedge clk);
        #1;
        check_idle("final", 18'h33F3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
